// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the ALU/mul-div block
package alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLT   = 4'd5,
      OP_SLL   = 4'd6,
      OP_SRL   = 4'd7,
      OP_SRA   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_PASSB = 4'd10,
      OP_MUL   = 4'd11,
      OP_MULHU = 4'd12,
      OP_DIVU  = 4'd13,
      OP_REMU  = 4'd14,
      OP_ALTB  = 4'd15
   } alu_op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;
   localparam logic [3:0] SINGLE_CYCLE_MAX = 4'd10;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, b_q, b_d, diff;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, div_q, div_d, ge;
   logic [WIDTH:0]   sum, rem;
   assign done = busy_q && cnt_q == CW'(WIDTH - 1);
   assign hi   = acc_d;
   assign lo   = q_d;
   // acc:q is the product pair for multiply and remainder:quotient for divide; a zero divisor naturally yields all-ones / dividend
   always_comb begin
      sum    = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
      rem    = {acc_q, q_q[WIDTH-1]};
      ge     = rem >= {1'b0, b_q};
      diff   = rem[WIDTH-1:0] - b_q;
      acc_d  = acc_q;
      q_d    = q_q;
      b_d    = b_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      div_d  = div_q;
      if (start) begin
         acc_d  = '0;
         q_d    = a;
         b_d    = b;
         cnt_d  = '0;
         busy_d = 1'b1;
         div_d  = is_div;
      end else if (busy_q) begin
         acc_d  = div_q ? (ge ? diff : rem[WIDTH-1:0]) : sum[WIDTH:1];
         q_d    = div_q ? {q_q[WIDTH-2:0], ge} : {sum[0], q_q[WIDTH-1:1]};
         cnt_d  = cnt_q + 1'b1;
         busy_d = !done;
      end
      if (flush) busy_d = 1'b0;
   end
   // iteration state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         q_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         div_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         q_q    <= q_d;
         b_q    <= b_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         div_q  <= div_d;
      end
   end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with iterative multiply/divide and a registered result
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic [3:0]       ALUControlE,
   input  logic             flush,
   output logic [WIDTH-1:0] ResultE,
   output logic             out_valid,
   output logic             StallE,
   output logic             ZeroE,
   output logic             LtE
);
   localparam int SW = $clog2(WIDTH);
   state_e           state_q, state_d;
   alu_op_e          op, op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d, alu_y, md_hi, md_lo, md_y;
   logic             out_valid_q, out_valid_d, accept, single, is_mul, start, md_done;
   logic [SW-1:0]    sh;
   assign op        = alu_op_e'(ALUControlE);
   assign sh        = SrcBE[SW-1:0];
   assign in_ready  = state_q == S_IDLE;
   assign StallE    = state_q == S_MUL || state_q == S_DIV;
   assign ZeroE     = SrcAE == SrcBE;
   assign LtE       = $signed(SrcAE) < $signed(SrcBE);
   assign ResultE   = result_q;
   assign out_valid = out_valid_q;
   assign accept    = in_valid && in_ready;
   assign single    = op <= SINGLE_CYCLE_MAX || op == OP_ALTB;
   assign is_mul    = op == OP_MUL || op == OP_MULHU;
   assign start     = accept && !single && !flush;
   assign md_y      = (op_q == OP_MUL || op_q == OP_DIVU) ? md_lo : md_hi;
   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .start  (start),
      .is_div (!is_mul),
      .a      (SrcAE),
      .b      (SrcBE),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );
   // single-cycle ALU operations; the reserved opcode falls through to PASSB
   always_comb begin
      alu_y = SrcBE;
      case (op)
         OP_ADD:  alu_y = SrcAE + SrcBE;
         OP_SUB:  alu_y = SrcAE - SrcBE;
         OP_AND:  alu_y = SrcAE & SrcBE;
         OP_OR:   alu_y = SrcAE | SrcBE;
         OP_XOR:  alu_y = SrcAE ^ SrcBE;
         OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)};
         OP_SLL:  alu_y = SrcAE << sh;
         OP_SRL:  alu_y = SrcAE >> sh;
         OP_SRA:  alu_y = $signed(SrcAE) >>> sh;
         OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, SrcAE < SrcBE};
         default: alu_y = SrcBE;
      endcase
   end
   // control FSM, result capture and completion pulse; flush aborts and blocks accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       state_d = start ? (is_mul ? S_MUL : S_DIV) : S_IDLE;
         S_MUL, S_DIV: state_d = md_done ? S_DONE : state_q;
         default:      state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
      op_d        = start ? op : op_q;
      out_valid_d = !flush && ((accept && single) || md_done);
      result_d    = flush ? result_q : (accept && single) ? alu_y : md_done ? md_y : result_q;
   end
   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ADD;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed table-driven bench for alu_muldiv at WIDTH=32
module tb_alu_muldiv;
   logic        clk = 1'b0;
   logic        rst, in_valid, flush, in_ready, out_valid, StallE, ZeroE, LtE;
   logic [31:0] SrcAE, SrcBE, ResultE;
   logic [3:0]  ALUControlE;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_y;
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;
   vec_t tbl[13];
   alu_muldiv #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .SrcAE       (SrcAE),
      .SrcBE       (SrcBE),
      .ALUControlE (ALUControlE),
      .flush       (flush),
      .ResultE     (ResultE),
      .out_valid   (out_valid),
      .StallE      (StallE),
      .ZeroE       (ZeroE),
      .LtE         (LtE)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic run_mc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
      in_valid = 1'b1;
      ALUControlE = op;
      SrcAE = a;
      SrcBE = b;
      tick();
      ALUControlE = 4'd0;
      SrcAE = 32'hFFFF_FFFF;
      SrcBE = 32'h0000_1234;
      for (int c = 1; c <= 34; c++) begin
         chk($sformatf("mc%0d_stall_c%0d", op, c), {31'b0, StallE}, {31'b0, c <= 32});
         chk($sformatf("mc%0d_ready_c%0d", op, c), {31'b0, in_ready}, {31'b0, c >= 34});
         chk($sformatf("mc%0d_valid_c%0d", op, c), {31'b0, out_valid}, {31'b0, c == 33});
         if (c == 33) begin
            chk($sformatf("mc%0d_result", op), ResultE, y);
            in_valid = 1'b0;
         end
         tick();
      end
      last_y = y;
   endtask
   initial begin
      tbl[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
      tbl[1]  = '{4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE};
      tbl[2]  = '{4'd2,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234};
      tbl[3]  = '{4'd3,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
      tbl[4]  = '{4'd4,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
      tbl[5]  = '{4'd5,  32'hFFFF_FFFF,  32'd1,          32'd1};
      tbl[6]  = '{4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0};
      tbl[7]  = '{4'd6,  32'd1,          32'h21,         32'd2};
      tbl[8]  = '{4'd7,  32'h8000_0000,  32'd4,          32'h0800_0000};
      tbl[9]  = '{4'd8,  32'h8000_0000,  32'h24,         32'hF800_0000};
      tbl[10] = '{4'd10, 32'd0,          32'hDEAD_BEEF,  32'hDEAD_BEEF};
      tbl[11] = '{4'd15, 32'd1,          32'hCAFE_F00D,  32'hCAFE_F00D};
      tbl[12] = '{4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0};
      rst = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      ALUControlE = 4'd0;
      SrcAE = '0;
      SrcBE = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_result", ResultE, 32'd0);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_stall", {31'b0, StallE}, 32'd0);
      SrcAE = 32'h1234;
      SrcBE = 32'h1234;
      #1 chk("zero_eq", {31'b0, ZeroE}, 32'd1);
      SrcBE = 32'h1235;
      #1 chk("zero_ne", {31'b0, ZeroE}, 32'd0);
      chk("lt_small", {31'b0, LtE}, 32'd1);
      SrcAE = 32'h8000_0000;
      SrcBE = 32'd0;
      #1 chk("lt_neg", {31'b0, LtE}, 32'd1);
      chk("lt_rev", {31'b0, ZeroE}, 32'd0);
      for (int i = 0; i < 13; i++) begin
         in_valid = 1'b1;
         ALUControlE = tbl[i].op;
         SrcAE = tbl[i].a;
         SrcBE = tbl[i].b;
         tick();
         chk($sformatf("alu%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("alu%0d_result", i), ResultE, tbl[i].y);
         last_y = tbl[i].y;
      end
      in_valid = 1'b0;
      tick();
      chk("pulse_end", {31'b0, out_valid}, 32'd0);
      chk("hold_result", ResultE, last_y);
      run_mc(4'd11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      run_mc(4'd12, 32'hFFFF_FFFF, 32'd2, 32'd1);
      run_mc(4'd12, 32'h0001_0000, 32'h0001_0000, 32'd1);
      run_mc(4'd13, 32'd100, 32'd7, 32'd14);
      run_mc(4'd14, 32'd100, 32'd7, 32'd2);
      run_mc(4'd13, 32'd100, 32'd0, 32'hFFFF_FFFF);
      run_mc(4'd14, 32'd100, 32'd0, 32'd100);
      chk("idle_after_mc", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      ALUControlE = 4'd13;
      SrcAE = 32'd1000;
      SrcBE = 32'd3;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      flush = 1'b1;
      in_valid = 1'b1;
      ALUControlE = 4'd0;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_ready", {31'b0, in_ready}, 32'd1);
      chk("flush_stall", {31'b0, StallE}, 32'd0);
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      begin
         int seen = 0;
         for (int c = 0; c < 40; c++) begin
            seen += int'(out_valid);
            tick();
         end
         chk("flush_no_completion", seen, 32'd0);
      end
      chk("flush_hold_result", ResultE, last_y);
      in_valid = 1'b1;
      flush = 1'b1;
      ALUControlE = 4'd0;
      SrcAE = 32'd1;
      SrcBE = 32'd1;
      tick();
      in_valid = 1'b0;
      flush = 1'b0;
      chk("flush_prio_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_prio_result", ResultE, last_y);
      in_valid = 1'b1;
      ALUControlE = 4'd11;
      SrcAE = 32'd3;
      SrcBE = 32'd5;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      chk("mid_mul_stall", {31'b0, StallE}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_result", ResultE, 32'd0);
      chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_mid_stall", {31'b0, StallE}, 32'd0);
      chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
      begin
         int seen = 0;
         for (int c = 0; c < 40; c++) begin
            seen += int'(out_valid);
            tick();
         end
         chk("rst_no_completion", seen, 32'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
